// File: rtl/peripheral_ram_arbiter_if.sv
// Requester, response and RAM-side signals of the peripheral RAM arbiter.
// The arbiter takes the slave modport; requesters and the RAM model take master.
interface peripheral_ram_arbiter_if #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*2-1:0]  req_wen;
  logic [NREQ*DW-1:0] req_din;
  logic [NREQ-1:0]    rsp_valid;
  logic               rsp_err;
  logic [DW-1:0]      rsp_data;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_din;
  logic               ram_cen;
  logic [1:0]         ram_wen;
  logic [DW-1:0]      ram_dout;

  modport slave (
    input  req_valid, req_addr, req_wen, req_din, ram_dout,
    output req_ready, rsp_valid, rsp_err, rsp_data,
           ram_addr, ram_din, ram_cen, ram_wen
  );

  modport master (
    output req_valid, req_addr, req_wen, req_din, ram_dout,
    input  req_ready, rsp_valid, rsp_err, rsp_data,
           ram_addr, ram_din, ram_cen, ram_wen
  );
endinterface

// File: rtl/peripheral_ram_arbiter.sv
// Round-robin arbiter in front of a single-port synchronous RAM.
// Two-stage pipeline: grant -> registered RAM access -> response.
module peripheral_ram_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEMORY_SIZE = 256,
  parameter int NREQ        = 2
) (
  input logic                     mclk,
  input logic                     rst,
  peripheral_ram_arbiter_if.slave bus
);
  localparam int              IW       = $clog2(NREQ);
  localparam logic [AW:0]     DEPTH    = (AW+1)'(MEMORY_SIZE / 2);
  localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);

  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic            s1_valid_q, s1_valid_d;
  logic [NREQ-1:0] s1_gnt_q, s1_gnt_d;
  logic            s1_read_q, s1_read_d;
  logic            s1_err_q, s1_err_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_din_q, ram_din_d;
  logic            ram_cen_q, ram_cen_d;
  logic [1:0]      ram_wen_q, ram_wen_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            rsp_read_q, rsp_read_d;
  logic            rsp_err_q, rsp_err_d;

  logic            found;
  logic [IW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;
  logic [AW-1:0]   sel_addr;
  logic [1:0]      sel_wen;
  logic [DW-1:0]   sel_din;
  logic            in_range;

  // Two ascending passes: indices above last_grant first, then the wrapped ones.
  always_comb begin
    found   = 1'b0;
    gnt_idx = last_grant_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rst && bus.req_valid[i] && (IW'(i) > last_grant_q)) begin
        found   = 1'b1;
        gnt_idx = IW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rst && bus.req_valid[i] && (IW'(i) <= last_grant_q)) begin
        found   = 1'b1;
        gnt_idx = IW'(i);
      end
    end
    gnt = found ? (NREQ'(1) << gnt_idx) : '0;
  end

  always_comb begin
    sel_addr = '0;
    sel_wen  = 2'b11;
    sel_din  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = bus.req_addr[i*AW +: AW];
        sel_wen  = bus.req_wen[i*2 +: 2];
        sel_din  = bus.req_din[i*DW +: DW];
      end
    end
    in_range = ({1'b0, sel_addr} < DEPTH);

    last_grant_d = found ? gnt_idx : last_grant_q;

    s1_valid_d = found;
    s1_gnt_d   = gnt;
    s1_read_d  = (sel_wen == 2'b11);
    s1_err_d   = found & ~in_range;
    ram_addr_d = found ? sel_addr : ram_addr_q;
    ram_din_d  = found ? sel_din : ram_din_q;
    ram_cen_d  = ~(found & in_range);
    ram_wen_d  = (found & in_range) ? sel_wen : 2'b11;

    // ram_dout for a read is only valid in the response cycle, so it is muxed there.
    rsp_valid_d = s1_valid_q ? s1_gnt_q : '0;
    rsp_read_d  = s1_valid_q & s1_read_q & ~s1_err_q;
    rsp_err_d   = s1_valid_q & s1_err_q;
  end

  always_ff @(posedge mclk) begin
    if (!rst) begin
      last_grant_q <= LAST_RST;
      s1_valid_q   <= 1'b0;
      s1_gnt_q     <= '0;
      s1_read_q    <= 1'b0;
      s1_err_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_cen_q    <= 1'b1;
      ram_wen_q    <= 2'b11;
      rsp_valid_q  <= '0;
      rsp_read_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      s1_valid_q   <= s1_valid_d;
      s1_gnt_q     <= s1_gnt_d;
      s1_read_q    <= s1_read_d;
      s1_err_q     <= s1_err_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_cen_q    <= ram_cen_d;
      ram_wen_q    <= ram_wen_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_read_q   <= rsp_read_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.ram_cen   = ram_cen_q;
  assign bus.ram_wen   = ram_wen_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_read_q ? bus.ram_dout : '0;
endmodule
